// File: rtl/mux_rr_sched.sv
// mux_rr_sched: chooses one of four requesting channels, steers an external 4:1 mux
// toward it, captures the mux output and holds that sample until the consumer accepts it.
//   clk       - sole clock; all state changes on its rising edge
//   rst       - synchronous active-high reset
//   req[3:0]  - per-channel requests (bit i = channel a/b/c/d)
//   sel[1:0]  - registered select driven to the downstream 4:1 mux
//   y_in      - mux output selected by sel
//   gnt[3:0]  - one-hot grant pulse to the served channel, high only in SELECT
//   out_data  - registered captured sample
//   out_valid - out_data holds a sample
//   out_ready - consumer accepts out_data when high together with out_valid
// Optional macro MUX_RR_SCHED_FIXED_PRIO_EN: fixed priority (channel 0 highest) instead of round-robin.
module mux_rr_sched #(
    parameter int DATA_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    output logic [1:0]        sel,
    input  logic [DATA_W-1:0] y_in,
    output logic [3:0]        gnt,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    typedef enum logic [1:0] {IDLE, SELECT, HOLD} state_t;
    state_t r_state, w_next;
    logic [1:0] r_last, w_win;
`ifndef MUX_RR_SCHED_FIXED_PRIO_EN
    logic [1:0] w_idx;
`endif
    // The loop runs from lowest to highest priority, so the last hit wins.
    always_comb begin
        w_win = r_last;
`ifdef MUX_RR_SCHED_FIXED_PRIO_EN
        for (int k = 3; k >= 0; k--)
            if (req[k]) w_win = 2'(k);
`else
        w_idx = r_last;
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_last + 2'(k);
            if (req[w_idx]) w_win = w_idx;
        end
`endif
    end
    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE)   ? ((|req) ? SELECT : IDLE) :
                 (r_state == SELECT) ? HOLD :
                 (out_ready ? IDLE : HOLD);
    end
    assign gnt = (r_state == SELECT) ? (4'b0001 << sel) : 4'b0000;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            sel       <= 2'b00;
            r_last    <= 2'd3;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && |req) sel <= w_win;
            if (r_state == SELECT) begin
                out_data  <= y_in;
                out_valid <= 1'b1;
            end
            if (r_state == HOLD && out_ready) begin
                out_valid <= 1'b0;
                r_last    <= sel;
            end
        end
    end
endmodule

// File: tb/tb_mux_rr_sched.sv
// tb_mux_rr_sched: directed table-driven bench for mux_rr_sched (round-robin build).
module tb_mux_rr_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       out_ready = 1'b1;
    logic [1:0] sel;
    logic [3:0] y_in, gnt, out_data;
    logic       out_valid;
    logic [3:0] chan [4] = '{4'h5, 4'h9, 4'h3, 4'hC};
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic [1:0] sel;
        logic [3:0] gnt;
        logic [3:0] data;
        logic       valid;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;
    assign y_in = chan[sel];

    mux_rr_sched #(.DATA_W(4)) dut (
        .clk(clk), .rst(rst), .req(req), .sel(sel), .y_in(y_in),
        .gnt(gnt), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    task automatic add(input logic r, input logic [3:0] rq, input logic rd,
                       input logic [1:0] s, input logic [3:0] g, input logic [3:0] d, input logic v);
        tv.push_back('{r, rq, rd, s, g, d, v});
    endtask

    task automatic check(input string name, input logic [1:0] s, input logic [3:0] g,
                         input logic [3:0] d, input logic v);
        n_vec++;
        if (sel !== s || gnt !== g || out_data !== d || out_valid !== v) begin
            n_err++;
            $display("FAIL %s: got sel=%0d gnt=%b data=%h valid=%b, want sel=%0d gnt=%b data=%h valid=%b",
                     name, sel, gnt, out_data, out_valid, s, g, d, v);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic rd);
        rst = r; req = rq; out_ready = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(1'b1, 4'b0000, 1'b1);
        check("reset", 2'd0, 4'b0000, 4'h0, 1'b0);
        // single request on ch0, dropped during SELECT: capture still happens
        add(0, 4'b0001, 1, 0, 4'b0001, 4'h0, 0);
        add(0, 4'b0000, 1, 0, 4'b0000, 4'h5, 1);
        add(0, 4'b0000, 1, 0, 4'b0000, 4'h5, 0);
        // reset beats a simultaneous request
        add(1, 4'b1111, 1, 0, 4'b0000, 4'h0, 0);
        // all requesting: ch0, ch1, ch2, ch3, ch0
        add(0, 4'b1111, 1, 0, 4'b0001, 4'h0, 0);
        add(0, 4'b1111, 1, 0, 4'b0000, 4'h5, 1);
        add(0, 4'b1111, 1, 0, 4'b0000, 4'h5, 0);
        add(0, 4'b1111, 1, 1, 4'b0010, 4'h5, 0);
        add(0, 4'b1111, 1, 1, 4'b0000, 4'h9, 1);
        add(0, 4'b1111, 1, 1, 4'b0000, 4'h9, 0);
        add(0, 4'b1111, 1, 2, 4'b0100, 4'h9, 0);
        add(0, 4'b1111, 1, 2, 4'b0000, 4'h3, 1);
        add(0, 4'b1111, 1, 2, 4'b0000, 4'h3, 0);
        add(0, 4'b1111, 1, 3, 4'b1000, 4'h3, 0);
        add(0, 4'b1111, 1, 3, 4'b0000, 4'hC, 1);
        add(0, 4'b1111, 1, 3, 4'b0000, 4'hC, 0);
        add(0, 4'b1111, 1, 0, 4'b0001, 4'hC, 0);
        add(0, 4'b1111, 1, 0, 4'b0000, 4'h5, 1);
        add(0, 4'b1111, 1, 0, 4'b0000, 4'h5, 0);
        // wrap-around with req=1010 from last=3: ch1, ch3, ch1
        add(1, 4'b0000, 1, 0, 4'b0000, 4'h0, 0);
        add(0, 4'b1010, 1, 1, 4'b0010, 4'h0, 0);
        add(0, 4'b1010, 1, 1, 4'b0000, 4'h9, 1);
        add(0, 4'b1010, 1, 1, 4'b0000, 4'h9, 0);
        add(0, 4'b1010, 1, 3, 4'b1000, 4'h9, 0);
        add(0, 4'b1010, 1, 3, 4'b0000, 4'hC, 1);
        add(0, 4'b1010, 1, 3, 4'b0000, 4'hC, 0);
        add(0, 4'b1010, 1, 1, 4'b0010, 4'hC, 0);
        add(0, 4'b1010, 1, 1, 4'b0000, 4'h9, 1);
        add(0, 4'b1010, 1, 1, 4'b0000, 4'h9, 0);
        // idle with no request keeps sel
        add(0, 4'b0000, 1, 1, 4'b0000, 4'h9, 0);
        add(0, 4'b0000, 0, 1, 4'b0000, 4'h9, 0);
        foreach (tv[i]) begin
            step(tv[i].rst, tv[i].req, tv[i].rdy);
            check($sformatf("vec%0d", i), tv[i].sel, tv[i].gnt, tv[i].data, tv[i].valid);
        end
        // stall: ch3 captured (last=1), consumer not ready for 5 cycles, new requests ignored
        step(0, 4'b1000, 0);
        check("stall_sel", 2'd3, 4'b1000, 4'h9, 1'b0);
        step(0, 4'b1111, 0);
        check("stall_cap", 2'd3, 4'b0000, 4'hC, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(0, 4'b1111, 0);
            check($sformatf("stall_hold%0d", i), 2'd3, 4'b0000, 4'hC, 1'b1);
        end
        step(0, 4'b1111, 1);
        check("stall_release", 2'd3, 4'b0000, 4'hC, 1'b0);
        step(0, 4'b1111, 0);
        check("after_stall_sel", 2'd0, 4'b0001, 4'hC, 1'b0);
        // reset while holding a valid sample
        step(0, 4'b0000, 0);
        check("hold_before_rst", 2'd0, 4'b0000, 4'h5, 1'b1);
        step(1, 4'b0000, 0);
        check("rst_in_hold", 2'd0, 4'b0000, 4'h0, 1'b0);
        // reset while in SELECT: no capture, no later grant
        step(0, 4'b0100, 1);
        check("sel_before_rst", 2'd2, 4'b0100, 4'h0, 1'b0);
        step(1, 4'b0000, 1);
        check("rst_in_select", 2'd0, 4'b0000, 4'h0, 1'b0);
        step(0, 4'b0000, 1);
        check("no_gnt_after_rst", 2'd0, 4'b0000, 4'h0, 1'b0);
        step(0, 4'b0000, 1);
        check("still_idle", 2'd0, 4'b0000, 4'h0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
